mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single doubleword-wide data-memory port between two requesters: the instruction-fetch path (IF, read-only) and the load/store path (LS, read/write with byte mask).
- Holds at most one outstanding transaction and routes each response back to the requester that owns it.
- Fixed priority goes to LS; a starvation counter guarantees IF forward progress.
- Sits between the fetch/LS stages and the memory model or bus adapter.

Parameters:
XLEN, 64, data and address width; the memory word is XLEN bits (8 byte lanes).
STARVE_MAX, 4, consecutive LS grants tolerated while IF is waiting before IF is forced ahead (range 1..15).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset, synchronous, active-low
if_req_valid  in  1  IF read request
if_req_ready  out  1  IF request accepted this cycle
if_addr  in  XLEN  IF byte address
if_rsp_valid  out  1  IF read data valid (1-cycle pulse)
if_rdata  out  XLEN  IF read doubleword
ls_req_valid  in  1  LS request
ls_req_ready  out  1  LS request accepted this cycle
ls_addr  in  XLEN  LS byte address
ls_wen  in  1  1 = write, 0 = read
ls_wdata  in  XLEN  write doubleword, already lane-merged
ls_wmask  in  8  byte-lane write enables
ls_rsp_valid  out  1  LS response valid (1-cycle pulse; read data or write ack)
ls_rdata  out  XLEN  LS read doubleword (0 for write acks)
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  XLEN  doubleword-aligned address (low 3 bits forced to 0)
mem_wen  out  1  write
mem_wdata  out  XLEN  write data
mem_wmask  out  8  byte mask; always 0 for reads
mem_rsp_valid  in  1  response, 1 cycle, for reads and writes
mem_rdata  in  XLEN  read data

Behaviour:
- Reset: when rst_n = 0 at a clock edge, the following are cleared:
  - state goes to IDLE; owner = IF; starve_cnt = 0; latched request fields are zeroed.
  - All outputs are 0 while in IDLE with no requests.
- State IDLE:
  - Grant selection is combinational:
    - if starve_cnt == STARVE_MAX and if_req_valid, grant IF;
    - else if ls_req_valid, grant LS;
    - else if if_req_valid, grant IF.
  - The winner's req_ready = 1 in the same cycle; the loser's req_ready = 0.
  - On handshake, latch addr & ~7, wen, wdata, and wmask (forced to 0 for reads and for IF), record owner, and go to REQ.
- State REQ:
  - mem_req_valid = 1, driven from the latched fields.
  - Both req_ready outputs = 0.
  - On mem_req_ready, go to RSP; otherwise hold and keep the fields stable.
- State RSP:
  - Wait for mem_rsp_valid. A mem_rsp_valid seen in REQ or IDLE is ignored.
  - On mem_rsp_valid, assert the owner's rsp_valid in the same cycle, combinationally.
    - The owner's rdata = mem_rdata for reads, 0 for writes.
    - The non-owner's rsp_valid and rdata are 0.
  - Then return to IDLE.
- Timing:
  - The earliest response is 2 cycles after the request handshake.
  - A new request can be accepted the cycle after the response, so peak throughput is 1 transaction per 3 cycles.
- Starvation counter (updated on each IDLE grant):
  - LS granted while if_req_valid = 1: increment, saturating at STARVE_MAX.
  - IF granted: clear to 0.
  - LS granted while if_req_valid = 0: clear to 0.
- Requesters must hold valid and fields stable until ready. The arbiter does not depend on this, because it latches at the handshake.
- ls_wmask = 0 with ls_wen = 1 is still issued as a write with mask 0, and is acked.
- Reset mid-transaction (REQ or RSP): the transaction is abandoned and no rsp_valid is produced. A later stray mem_rsp_valid is ignored in IDLE.
- Unaligned addresses are not errors; the low 3 bits are dropped and lane selection is the requester's job.

Test Plan:
- IF-only read, if_addr = 0x8000_0004: if_req_ready same cycle → mem_addr = 0x8000_0000, mem_wen = 0, mem_wmask = 0. With mem_req_ready = 1 and mem_rsp_valid 1 cycle later carrying 0x1122334455667788: if_rsp_valid pulses once with that data; ls_rsp_valid stays 0.
- LS write then read to 0x8000_0010: write with wmask = 0x0F, wdata = 0xDEAD_BEEF → mem_wen = 1, mem_wmask = 0x0F; ack gives ls_rsp_valid = 1 with ls_rdata = 0. The following read returns mem_rdata on ls_rdata.
- Both valid in the same IDLE cycle, starve_cnt = 0: ls_req_ready = 1, if_req_ready = 0. LS completes; the next IDLE cycle grants IF, if LS is then idle.
- STARVE_MAX = 4, both held valid continuously: grant sequence is LS, LS, LS, LS, IF, LS, … and starve_cnt returns to 0 after the IF grant.
- Backpressure: hold mem_req_ready = 0 for 3 cycles in REQ → mem_req_valid stays 1 with stable address/data, both req_ready = 0, and a mem_rsp_valid injected during REQ is ignored.
- Reset in RSP: assert rst_n = 0 for 1 cycle → next cycle IDLE with all outputs 0. A later mem_rsp_valid produces no rsp_valid, and a new IF request is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single doubleword data-memory port.
// Load/store wins by default; a starvation counter forces fetch through after STARVE_MAX LS wins.
module mem_port_arbiter #(
  parameter int XLEN       = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_rsp_valid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            ls_req_valid,
  output logic            ls_req_ready,
  input  logic [XLEN-1:0] ls_addr,
  input  logic            ls_wen,
  input  logic [XLEN-1:0] ls_wdata,
  input  logic [7:0]      ls_wmask,
  output logic            ls_rsp_valid,
  output logic [XLEN-1:0] ls_rdata,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(7);
  localparam logic [3:0]      STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]      state;
  logic            owner;
  logic [3:0]      starve_cnt;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;
  logic            lat_wen;
  logic [7:0]      lat_wmask;

  logic idle, starved, grant_if, grant_ls, in_req, rsp_fire;

  assign idle    = (state == S_IDLE);
  assign starved = (starve_cnt == STARVE_LIM);

  // A starved fetch beats a pending load/store; otherwise LS has priority.
  assign grant_if = idle && if_req_valid && (starved || !ls_req_valid);
  assign grant_ls = idle && ls_req_valid && !(starved && if_req_valid);

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  // Memory-side fields are gated so the port reads all-zero outside REQ.
  assign in_req        = (state == S_REQ);
  assign mem_req_valid = in_req;
  assign mem_addr      = in_req ? lat_addr  : '0;
  assign mem_wen       = in_req && lat_wen;
  assign mem_wdata     = in_req ? lat_wdata : '0;
  assign mem_wmask     = in_req ? lat_wmask : '0;

  assign rsp_fire     = (state == S_RSP) && mem_rsp_valid;
  assign if_rsp_valid = rsp_fire && (owner == OWN_IF);
  assign ls_rsp_valid = rsp_fire && (owner == OWN_LS);
  assign if_rdata     = if_rsp_valid ? mem_rdata : '0;
  assign ls_rdata     = (ls_rsp_valid && !lat_wen) ? mem_rdata : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner      <= OWN_IF;
      starve_cnt <= '0;
      // NOTE: the latched request fields are cleared too, so nothing stale is ever observable.
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wen    <= 1'b0;
      lat_wmask  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_ls) begin
            state     <= S_REQ;
            owner     <= OWN_LS;
            lat_addr  <= ls_addr & ALIGN_MASK;
            lat_wen   <= ls_wen;
            lat_wdata <= ls_wdata;
            lat_wmask <= ls_wen ? ls_wmask : 8'h00;
            if (!if_req_valid)
              starve_cnt <= '0;
            else if (!starved)
              starve_cnt <= starve_cnt + 4'd1;
          end else if (grant_if) begin
            state      <= S_REQ;
            owner      <= OWN_IF;
            lat_addr   <= if_addr & ALIGN_MASK;
            lat_wen    <= 1'b0;
            lat_wdata  <= '0;
            lat_wmask  <= 8'h00;
            starve_cnt <= '0;
          end
        end
        S_REQ: begin
          if (mem_req_ready)
            state <= S_RSP;
        end
        S_RSP: begin
          if (mem_rsp_valid)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected responses are queued at request
// time and compared when the arbiter returns a response.
module tb_mem_port_arbiter;

  localparam int XLEN       = 64;
  localparam int STARVE_MAX = 4;

  logic            clk;
  logic            rst_n;
  logic            if_req_valid, if_req_ready, if_rsp_valid;
  logic [XLEN-1:0] if_addr, if_rdata;
  logic            ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid;
  logic [XLEN-1:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]      ls_wmask;
  logic            mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]      mem_wmask;

  typedef struct {
    bit          is_ls;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  mem_port_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_addr       (if_addr),
    .if_rsp_valid  (if_rsp_valid),
    .if_rdata      (if_rdata),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_addr       (ls_addr),
    .ls_wen        (ls_wen),
    .ls_wdata      (ls_wdata),
    .ls_wmask      (ls_wmask),
    .ls_rsp_valid  (ls_rsp_valid),
    .ls_rdata      (ls_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "/req_ready"}, {62'd0, if_req_ready, ls_req_ready}, 64'd0);
    check({tag, "/rsp_valid"}, {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd0);
    check({tag, "/rdata"}, if_rdata | ls_rdata, 64'd0);
    check({tag, "/mem_req_valid"}, {63'd0, mem_req_valid}, 64'd0);
    check({tag, "/mem_fields"}, mem_addr | mem_wdata | {55'd0, mem_wen, mem_wmask}, 64'd0);
  endtask

  // One full transaction: IDLE grant, optional REQ stall cycles, then a response.
  task automatic txn(input string tag, input bit v_if, input bit v_ls, input bit exp_ls,
                     input logic [63:0] a_if, input logic [63:0] a_ls, input bit wen,
                     input logic [63:0] wdata, input logic [7:0] wmask,
                     input logic [63:0] rdata, input int stall, input bit keep);
    exp_t        e;
    logic [63:0] e_addr;
    bit          e_wen;
    logic [7:0]  e_mask;
    bit          any;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    if_req_valid  = v_if;
    if_addr       = a_if;
    ls_req_valid  = v_ls;
    ls_addr       = a_ls;
    ls_wen        = wen;
    ls_wdata      = wdata;
    ls_wmask      = wmask;
    #1;
    check({tag, "/idle_rsp_quiet"}, {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd0);
    check({tag, "/ls_req_ready"}, {63'd0, ls_req_ready}, {63'd0, exp_ls});
    check({tag, "/if_req_ready"}, {63'd0, if_req_ready}, {63'd0, !exp_ls});
    e_addr  = (exp_ls ? a_ls : a_if) & ~64'h7;
    e_wen   = exp_ls && wen;
    e_mask  = e_wen ? wmask : 8'h00;
    e.is_ls = exp_ls;
    e.data  = e_wen ? 64'h0 : rdata;
    sb.push_back(e);
    @(posedge clk);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!keep) begin
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
      end
      mem_req_ready = 1'b0;
      mem_rsp_valid = (i == 0);
      mem_rdata     = 64'hBAD0_BAD0_BAD0_BAD0;
      #1;
      check({tag, "/stall_valid"}, {63'd0, mem_req_valid}, 64'd1);
      check({tag, "/stall_addr"}, mem_addr, e_addr);
      if (e_wen) check({tag, "/stall_wdata"}, mem_wdata, wdata);
      check({tag, "/stall_ready"}, {62'd0, if_req_ready, ls_req_ready}, 64'd0);
      check({tag, "/stall_rsp_ignored"}, {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd0);
      @(posedge clk);
    end
    @(negedge clk);
    if (!keep) begin
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    check({tag, "/mem_req_valid"}, {63'd0, mem_req_valid}, 64'd1);
    check({tag, "/mem_addr"}, mem_addr, e_addr);
    check({tag, "/mem_wen"}, {63'd0, mem_wen}, {63'd0, e_wen});
    check({tag, "/mem_wmask"}, {56'd0, mem_wmask}, {56'd0, e_mask});
    if (e_wen) check({tag, "/mem_wdata"}, mem_wdata, wdata);
    check({tag, "/req_ready_low"}, {62'd0, if_req_ready, ls_req_ready}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = rdata;
    #1;
    any = if_rsp_valid || ls_rsp_valid;
    check({tag, "/rsp_seen"}, {63'd0, any}, 64'd1);
    if (any && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "/ls_rsp_valid"}, {63'd0, ls_rsp_valid}, {63'd0, e.is_ls});
      check({tag, "/if_rsp_valid"}, {63'd0, if_rsp_valid}, {63'd0, !e.is_ls});
      check({tag, "/owner_rdata"}, e.is_ls ? ls_rdata : if_rdata, e.data);
      check({tag, "/other_rdata"}, e.is_ls ? if_rdata : ls_rdata, 64'd0);
    end
    @(posedge clk);
  endtask

  bit pattern [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    rst_n         = 1'b0;
    if_req_valid  = 1'b0;
    if_addr       = '0;
    ls_req_valid  = 1'b0;
    ls_addr       = '0;
    ls_wen        = 1'b0;
    ls_wdata      = '0;
    ls_wmask      = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_quiet("reset");

    txn("if_rd", 1, 0, 0, 64'h8000_0004, 64'h0, 0, 64'h0, 8'h00,
        64'h1122_3344_5566_7788, 0, 0);
    txn("ls_wr", 0, 1, 1, 64'h0, 64'h8000_0010, 1, 64'hDEAD_BEEF, 8'h0F,
        64'hFFFF_0000_1234_5678, 0, 0);
    txn("ls_rd", 0, 1, 1, 64'h0, 64'h8000_0010, 0, 64'h5555_5555_5555_5555, 8'hFF,
        64'hCAFE_F00D_0BAD_BEEF, 0, 0);

    txn("both_ls", 1, 1, 1, 64'h1000, 64'h2000, 0, 64'h0, 8'h00,
        64'h0000_0000_0000_2000, 0, 0);
    txn("both_if", 1, 0, 0, 64'h1000, 64'h0, 0, 64'h0, 8'h00,
        64'h0000_0000_0000_1000, 0, 0);

    for (int i = 0; i < 10; i++)
      txn($sformatf("starve%0d", i), 1, 1, pattern[i], 64'h4000 + 64'(i * 8),
          64'h6000 + 64'(i * 8), 0, 64'h0, 8'h00, 64'hA000_0000_0000_0000 + 64'(i), 0, 1);
    @(negedge clk);
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;

    txn("backpressure", 0, 1, 1, 64'h0, 64'h3009, 1, 64'h0123_4567_89AB_CDEF, 8'hA5,
        64'h1111_2222_3333_4444, 3, 0);
    txn("wmask0", 0, 1, 1, 64'h0, 64'h7000, 1, 64'h7777_7777_7777_7777, 8'h00,
        64'h9999_9999_9999_9999, 0, 0);

    // Abandon an IF read in RSP via reset, then make sure a stray response is dropped.
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    if_req_valid  = 1'b1;
    if_addr       = 64'h0000_0100;
    #1;
    check("rst_rsp/if_req_ready", {63'd0, if_req_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    check("rst_rsp/mem_addr", mem_addr, 64'h0000_0100);
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst_n         = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_quiet("rst_rsp/idle");
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'hDEAD_DEAD_DEAD_DEAD;
    #1;
    check("rst_rsp/stray_ignored", {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd0);
    @(posedge clk);
    txn("after_rst", 1, 0, 0, 64'h0000_0208, 64'h0, 0, 64'h0, 8'h00,
        64'h0102_0304_0506_0708, 0, 0);

    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    check_quiet("final_idle");
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
